// File: rtl/memory_interface.sv
// Byte-wide external memory bridge: captures MAR/bus data, runs a four-phase req/ack
// handshake and latches read data. Define MEM_TIMEOUT_EN to abort requests left unacknowledged.
module memory_interface #(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_output_enable,
  input  logic [15:0] mar_value,
  inout  wire  [7:0]  data_bus,
  output logic        busy,
  output logic        done,
  output logic        bus_error,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  output logic        ext_we,
  output logic        ext_req,
  input  logic        ext_ack,
  input  logic [7:0]  ext_rdata
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic [1:0] {StIdle, StRequest, StRelease} state_e;

  state_e      state_q, state_d;
  logic [15:0] ext_addr_q, ext_addr_d;
  logic [7:0]  ext_wdata_q, ext_wdata_d;
  logic        ext_we_q, ext_we_d;
  logic        ext_req_q, ext_req_d;
  logic [7:0]  read_latch_q, read_latch_d;
  logic        done_q, done_d;
  logic        bus_error_q, bus_error_d;
`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  wait_count_q, wait_count_d;
`endif

  always_comb begin
    state_d      = state_q;
    ext_addr_d   = ext_addr_q;
    ext_wdata_d  = ext_wdata_q;
    ext_we_d     = ext_we_q;
    ext_req_d    = ext_req_q;
    read_latch_d = read_latch_q;
    done_d       = 1'b0;
    bus_error_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
    wait_count_d = wait_count_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (mem_read ^ mem_write) begin
          ext_addr_d = mar_value;
          if (mem_write) ext_wdata_d = data_bus;
          ext_we_d   = mem_write;
          ext_req_d  = 1'b1;
          state_d    = StRequest;
        end else if (mem_read && mem_write) begin
          bus_error_d = 1'b1;
        end
      end
      StRequest: begin
        if (ext_ack) begin
          if (!ext_we_q) read_latch_d = ext_rdata;
          ext_req_d = 1'b0;
          state_d   = StRelease;
        end
`ifdef MEM_TIMEOUT_EN
        else if (wait_count_q == TimeoutLast) begin
          // Abort: memory never answered; read_latch is deliberately left alone.
          ext_req_d    = 1'b0;
          ext_we_d     = 1'b0;
          bus_error_d  = 1'b1;
          wait_count_d = 8'd0;
          state_d      = StIdle;
        end else begin
          wait_count_d = wait_count_q + 8'd1;
        end
`endif
      end
      StRelease: begin
        if (!ext_ack) begin
          done_d   = 1'b1;
          ext_we_d = 1'b0;
          state_d  = StIdle;
`ifdef MEM_TIMEOUT_EN
          wait_count_d = 8'd0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      ext_addr_q   <= 16'h0000;
      ext_wdata_q  <= 8'h00;
      ext_we_q     <= 1'b0;
      ext_req_q    <= 1'b0;
      read_latch_q <= 8'h00;
      done_q       <= 1'b0;
      bus_error_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_count_q <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      ext_addr_q   <= ext_addr_d;
      ext_wdata_q  <= ext_wdata_d;
      ext_we_q     <= ext_we_d;
      ext_req_q    <= ext_req_d;
      read_latch_q <= read_latch_d;
      done_q       <= done_d;
      bus_error_q  <= bus_error_d;
`ifdef MEM_TIMEOUT_EN
      wait_count_q <= wait_count_d;
`endif
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign bus_error = bus_error_q;
  assign ext_addr  = ext_addr_q;
  assign ext_wdata = ext_wdata_q;
  assign ext_we    = ext_we_q;
  assign ext_req   = ext_req_q;
  assign data_bus  = mem_output_enable ? read_latch_q : 8'hzz;

endmodule

// File: tb/tb_memory_interface.sv
// Bench for memory_interface: transaction-level model checked every cycle plus directed
// literal expectations. Timeout scenario only runs when MEM_TIMEOUT_EN is defined.
module tb_memory_interface;

  localparam int unsigned TO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        mem_output_enable = 1'b0;
  logic [15:0] mar_value = 16'h0000;
  wire  [7:0]  data_bus;
  logic        busy, done, bus_error, ext_we, ext_req;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic        ext_ack = 1'b0;
  logic [7:0]  ext_rdata = 8'h00;

  logic        bus_drv_en = 1'b0;
  logic [7:0]  bus_drv = 8'h00;
  assign data_bus = bus_drv_en ? bus_drv : 8'hzz;

  memory_interface #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_output_enable(mem_output_enable), .mar_value(mar_value), .data_bus(data_bus),
    .busy(busy), .done(done), .bus_error(bus_error), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_we(ext_we), .ext_req(ext_req), .ext_ack(ext_ack),
    .ext_rdata(ext_rdata)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: acks after wait_n extra cycles of req, drops ack once req falls.
  int wait_n = 0;
  bit no_ack = 1'b0;
  int req_cycles = 0;
  always @(posedge clock) begin
    #1;
    if (ext_req) begin
      req_cycles++;
      if (!no_ack && req_cycles > wait_n) ext_ack = 1'b1;
    end else begin
      req_cycles = 0;
      ext_ack = 1'b0;
    end
  end

  // Transaction-level reference: one transfer in flight, split into "awaiting ack" and
  // "awaiting ack release".
  bit          m_active = 0, m_acked = 0, m_we = 0, m_done = 0, m_err = 0;
  logic [15:0] m_addr = 16'h0;
  logic [7:0]  m_wdata = 8'h0, m_latch = 8'h0;
  int          m_waited = 0;

  always @(posedge clock) begin
    m_done = 0;
    m_err  = 0;
    if (reset) begin
      m_active = 0; m_acked = 0; m_we = 0;
      m_addr = 16'h0; m_wdata = 8'h0; m_latch = 8'h0; m_waited = 0;
    end else if (!m_active) begin
      if (mem_read && mem_write) m_err = 1;
      else if (mem_read || mem_write) begin
        m_active = 1; m_acked = 0; m_waited = 0;
        m_addr = mar_value;
        if (mem_write) m_wdata = data_bus;
        m_we = mem_write;
      end
    end else if (!m_acked) begin
      if (ext_ack) begin
        m_acked = 1;
        if (!m_we) m_latch = ext_rdata;
      end else begin
        m_waited++;
`ifdef MEM_TIMEOUT_EN
        if (m_waited == TO) begin
          m_active = 0; m_we = 0; m_err = 1;
        end
`endif
      end
    end else if (!ext_ack) begin
      m_active = 0; m_we = 0; m_done = 1;
    end
  end

  always @(negedge clock) begin
    if (done === 1'b1) done_cnt++;
    if (chk_en) begin
      check("busy", busy, m_active);
      check("done", done, m_done);
      check("bus_error", bus_error, m_err);
      check("ext_req", ext_req, m_active && !m_acked);
      check("ext_we", ext_we, m_we);
      check("ext_addr", ext_addr, m_addr);
      check("ext_wdata", ext_wdata, m_wdata);
      if (mem_output_enable) check("data_bus", data_bus, m_latch);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic rd, input logic wr, input logic [15:0] addr);
    mem_read = rd; mem_write = wr; mar_value = addr;
    tick();
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // Returns the cycle at which done (sel=0) or bus_error (sel=1) is seen, or -1.
  task automatic wait_pulse(input bit sel, input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clock);
      if ((sel ? bus_error : done) === 1'b1) begin
        at = cyc;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  int c0, at, d0;

  initial begin
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clock);
    check("reset_busy", busy, 0);
    check("reset_req", ext_req, 0);
    check("reset_addr", ext_addr, 16'h0000);
    tick();

    // Zero-wait read.
    ext_rdata = 8'hA5; wait_n = 0;
    c0 = cyc;
    strobe(1'b1, 1'b0, 16'h1234);
    wait_pulse(1'b0, 20, at);
    check("read_done_latency", at, c0 + 3);
    check("read_addr", ext_addr, 16'h1234);
    check("read_we", ext_we, 0);
    mem_output_enable = 1'b1;
    @(negedge clock);
    check("read_bus", data_bus, 8'hA5);
    tick();
    mem_output_enable = 1'b0;

    // Write with 5 wait cycles.
    wait_n = 5;
    bus_drv = 8'h3C; bus_drv_en = 1'b1;
    strobe(1'b0, 1'b1, 16'hFFFF);
    bus_drv_en = 1'b0; bus_drv = 8'h00;
    repeat (3) @(negedge clock);
    check("write_wdata", ext_wdata, 8'h3C);
    check("write_we", ext_we, 1);
    check("write_req_waiting", ext_req, 1);
    wait_pulse(1'b0, 30, at);
    check("write_done_seen", at != -1, 1);
    @(negedge clock);
    check("write_busy_after", busy, 0);
    tick();

    // Simultaneous strobes.
    strobe(1'b1, 1'b1, 16'h5555);
    @(negedge clock);
    check("both_error", bus_error, 1);
    check("both_req", ext_req, 0);
    check("both_busy", busy, 0);
    tick();

`ifdef MEM_TIMEOUT_EN
    no_ack = 1'b1;
    c0 = cyc;
    strobe(1'b1, 1'b0, 16'h0F0F);
    wait_pulse(1'b1, 20, at);
    check("timeout_latency", at, c0 + 1 + TO);
    check("timeout_req", ext_req, 0);
    mem_output_enable = 1'b1;
    @(negedge clock);
    check("timeout_latch_kept", data_bus, 8'hA5);
    tick();
    mem_output_enable = 1'b0;
    no_ack = 1'b0;
`endif

    // Strobe while busy is ignored.
    wait_n = 3; ext_rdata = 8'h5A;
    d0 = done_cnt;
    strobe(1'b1, 1'b0, 16'h0100);
    strobe(1'b1, 1'b0, 16'h0001);
    @(negedge clock);
    check("busy_addr_kept", ext_addr, 16'h0100);
    wait_pulse(1'b0, 30, at);
    repeat (6) tick();
    check("busy_one_done", done_cnt - d0, 1);
    check("busy_addr_final", ext_addr, 16'h0100);

    // Reset during REQUEST.
    no_ack = 1'b1;
    d0 = done_cnt;
    strobe(1'b1, 1'b0, 16'h2222);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_output_enable = 1'b1;
    @(negedge clock);
    check("rst_req", ext_req, 0);
    check("rst_busy", busy, 0);
    check("rst_latch", data_bus, 8'h00);
    repeat (4) tick();
    check("rst_no_done", done_cnt - d0, 0);
    mem_output_enable = 1'b0;
    no_ack = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
